// File: rtl/io_mmio_port_if.sv
// Core data-bus connection for io_mmio_port: single-cycle request, registered
// one-cycle acknowledge carrying read data and an error flag.
interface io_mmio_port_if;
    logic        bus_req;
    logic        bus_we;
    logic [31:0] bus_addr;
    logic [31:0] bus_wdata;
    logic [31:0] bus_rdata;
    logic        bus_ack;
    logic        bus_err;

    modport master (
        output bus_req, bus_we, bus_addr, bus_wdata,
        input  bus_rdata, bus_ack, bus_err
    );

    modport slave (
        input  bus_req, bus_we, bus_addr, bus_wdata,
        output bus_rdata, bus_ack, bus_err
    );
endinterface

// File: rtl/io_mmio_port.sv
// io_mmio_port: memory-mapped responder exposing synchronised operand pins as
// read-only registers and driving a core-written result word onto output pins.
module io_mmio_port #(
    parameter logic [31:0] BASE_ADDR   = 32'h0000_7F00,
    parameter int          OPR_W       = 8,
    parameter int          RES_W       = 16,
    parameter int          SYNC_STAGES = 2
) (
    input  logic             base_clk,
    input  logic             reset,
    input  logic [OPR_W-1:0] opr1,
    input  logic [OPR_W-1:0] opr2,
    output logic [RES_W-1:0] result,
    output logic             result_valid,
    io_mmio_port_if.slave    mmio
);
    localparam logic [1:0] IDX_OPR1 = 2'd0;
    localparam logic [1:0] IDX_OPR2 = 2'd1;
    localparam logic [1:0] IDX_RES  = 2'd2;
    localparam logic [1:0] IDX_STAT = 2'd3;

    function automatic logic [7:0] sat_inc8(input logic [7:0] v);
        return (v == 8'hFF) ? v : v + 8'd1;
    endfunction

    logic [OPR_W-1:0] opr1_sync_q [SYNC_STAGES];
    logic [OPR_W-1:0] opr2_sync_q [SYNC_STAGES];
    logic [OPR_W-1:0] opr1_s, opr2_s;
    logic [OPR_W-1:0] opr1_prev_q, opr2_prev_q;

    logic [RES_W-1:0] result_q, result_d;
    logic             valid_q, valid_d;
    logic             chg_q, chg_d;
    logic [7:0]       wcnt_q, wcnt_d;
    logic             ack_q, ack_d;
    logic             err_q, err_d;
    logic [31:0]      rdata_q, rdata_d;

    logic       hit;
    logic [1:0] idx;
    logic       opr_chg;
    logic       unused_bits;

    assign opr1_s  = opr1_sync_q[SYNC_STAGES-1];
    assign opr2_s  = opr2_sync_q[SYNC_STAGES-1];
    assign hit     = mmio.bus_req && (mmio.bus_addr[31:4] == BASE_ADDR[31:4]);
    assign idx     = mmio.bus_addr[3:2];
    assign opr_chg = (opr1_s != opr1_prev_q) || (opr2_s != opr2_prev_q);
    // Byte offset and the upper write-data bits carry no meaning here.
    assign unused_bits = ^{mmio.bus_addr[1:0], mmio.bus_wdata};

    always_ff @(posedge base_clk or negedge reset) begin
        if (!reset) begin
            for (int i = 0; i < SYNC_STAGES; i++) begin
                opr1_sync_q[i] <= '0;
                opr2_sync_q[i] <= '0;
            end
            opr1_prev_q <= '0;
            opr2_prev_q <= '0;
        end else begin
            opr1_sync_q[0] <= opr1;
            opr2_sync_q[0] <= opr2;
            for (int i = 1; i < SYNC_STAGES; i++) begin
                opr1_sync_q[i] <= opr1_sync_q[i-1];
                opr2_sync_q[i] <= opr2_sync_q[i-1];
            end
            opr1_prev_q <= opr1_s;
            opr2_prev_q <= opr2_s;
        end
    end

    always_comb begin
        ack_d    = hit;
        err_d    = 1'b0;
        rdata_d  = '0;
        result_d = result_q;
        valid_d  = valid_q;
        wcnt_d   = wcnt_q;
        chg_d    = chg_q;
        if (hit) begin
            if (mmio.bus_we) begin
                case (idx)
                    IDX_OPR1, IDX_OPR2: err_d = 1'b1;
                    IDX_RES: begin
                        result_d = mmio.bus_wdata[RES_W-1:0];
                        valid_d  = 1'b1;
                        wcnt_d   = sat_inc8(wcnt_q);
                    end
                    default: begin
                        if (mmio.bus_wdata[1]) valid_d = 1'b0;
                    end
                endcase
            end else begin
                case (idx)
                    IDX_OPR1: rdata_d = 32'(opr1_s);
                    IDX_OPR2: rdata_d = 32'(opr2_s);
                    IDX_RES:  rdata_d = 32'(result_q);
                    default: begin
                        rdata_d = {16'h0000, wcnt_q, 6'b000000, valid_q, chg_q};
                        chg_d   = 1'b0;
                    end
                endcase
            end
        end
        // A fresh operand change must not be lost to a simultaneous clear-on-read.
        if (opr_chg) chg_d = 1'b1;
    end

    always_ff @(posedge base_clk or negedge reset) begin
        if (!reset) begin
            result_q <= '0;
            valid_q  <= 1'b0;
            chg_q    <= 1'b0;
            wcnt_q   <= '0;
            ack_q    <= 1'b0;
            err_q    <= 1'b0;
            rdata_q  <= '0;
        end else begin
            result_q <= result_d;
            valid_q  <= valid_d;
            chg_q    <= chg_d;
            wcnt_q   <= wcnt_d;
            ack_q    <= ack_d;
            err_q    <= err_d;
            rdata_q  <= rdata_d;
        end
    end

    assign result         = result_q;
    assign result_valid   = valid_q;
    assign mmio.bus_ack   = ack_q;
    assign mmio.bus_err   = err_q;
    assign mmio.bus_rdata = rdata_q;
endmodule

// File: tb/tb_io_mmio_port.sv
// Bench for io_mmio_port: directed vector table, hand-written corner sequences
// and a randomized run against a delay-line/register-map reference model.
`timescale 1ns/1ps
module tb_io_mmio_port;
    localparam logic [31:0] BASE = 32'h0000_7F00;
    localparam int          SYNC = 2;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [7:0]  opr1_pin, opr2_pin;
    logic [15:0] result;
    logic        result_valid;

    io_mmio_port_if mmio();

    io_mmio_port #(
        .BASE_ADDR(BASE), .OPR_W(8), .RES_W(16), .SYNC_STAGES(SYNC)
    ) dut (
        .base_clk(clk), .reset(rst_n), .opr1(opr1_pin), .opr2(opr2_pin),
        .result(result), .result_valid(result_valid), .mmio(mmio)
    );

    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_bad = 0;

    logic [15:0] m_res;
    logic        m_rv, m_chg;
    int          m_wcnt;
    logic [7:0]  h1[$], h2[$];
    logic        e_ack, e_err;
    logic [31:0] e_rdata;

    typedef struct {
        logic [1:0]  op;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [7:0]  o2;
        logic        eack;
        logic        eerr;
        logic [31:0] erd;
        logic [15:0] eres;
        logic        erv;
    } vec_t;

    vec_t tbl[28];

    function automatic vec_t mk(input logic [1:0] op, input logic [31:0] addr,
                                input logic [31:0] wdata, input logic [7:0] o2,
                                input logic eack, input logic eerr,
                                input logic [31:0] erd, input logic [15:0] eres,
                                input logic erv);
        vec_t v;
        v.op = op; v.addr = addr; v.wdata = wdata; v.o2 = o2;
        v.eack = eack; v.eerr = eerr; v.erd = erd; v.eres = eres; v.erv = erv;
        return v;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic model_reset();
        m_res = '0; m_rv = 1'b0; m_chg = 1'b0; m_wcnt = 0;
        h1 = {}; h2 = {};
        for (int i = 0; i <= SYNC; i++) begin
            h1.push_back(8'h00);
            h2.push_back(8'h00);
        end
    endtask

    // Operand register = pin value SYNC edges old; chg watches that value move.
    task automatic model_edge();
        logic [7:0] s1, s2, p1, p2;
        logic       hit, srd;
        logic [1:0] idx;
        s1 = h1[SYNC-1]; p1 = h1[SYNC];
        s2 = h2[SYNC-1]; p2 = h2[SYNC];
        hit = mmio.bus_req && ((mmio.bus_addr & ~32'hF) == BASE);
        idx = mmio.bus_addr[3:2];
        srd = 1'b0;
        e_ack = hit;
        e_err = hit && mmio.bus_we && (idx < 2'd2);
        e_rdata = '0;
        if (hit && !mmio.bus_we) begin
            case (idx)
                2'd0: e_rdata = 32'(s1);
                2'd1: e_rdata = 32'(s2);
                2'd2: e_rdata = 32'(m_res);
                default: begin
                    e_rdata = 32'(m_wcnt) * 256 + (m_rv ? 2 : 0) + (m_chg ? 1 : 0);
                    srd = 1'b1;
                end
            endcase
        end
        if (hit && mmio.bus_we && idx == 2'd2) begin
            m_res = mmio.bus_wdata[15:0];
            m_rv  = 1'b1;
            if (m_wcnt < 255) m_wcnt++;
        end
        if (hit && mmio.bus_we && idx == 2'd3 && mmio.bus_wdata[1]) m_rv = 1'b0;
        if (s1 != p1 || s2 != p2) m_chg = 1'b1;
        else if (srd) m_chg = 1'b0;
        h1.push_front(opr1_pin); void'(h1.pop_back());
        h2.push_front(opr2_pin); void'(h2.pop_back());
    endtask

    task automatic step(input logic req, input logic we, input logic [31:0] addr,
                        input logic [31:0] wdata);
        mmio.bus_req = req; mmio.bus_we = we; mmio.bus_addr = addr; mmio.bus_wdata = wdata;
        @(posedge clk);
        model_edge();
        #1;
        chk("model_ack", 32'(mmio.bus_ack), 32'(e_ack));
        chk("model_err", 32'(mmio.bus_err), 32'(e_err));
        if (e_ack) chk("model_rdata", mmio.bus_rdata, e_rdata);
        chk("model_result", 32'(result), 32'(m_res));
        chk("model_valid", 32'(result_valid), 32'(m_rv));
        mmio.bus_req = 1'b0;
    endtask

    initial begin
        logic [15:0] last_res;
        logic [31:0] raddr;
        opr1_pin = 8'd62; opr2_pin = 8'd125;
        mmio.bus_req = 1'b0; mmio.bus_we = 1'b0; mmio.bus_addr = '0; mmio.bus_wdata = '0;

        tbl[0]  = mk(0, 0, 0, 125, 0, 0, 0, 16'h0000, 0);
        tbl[1]  = mk(0, 0, 0, 125, 0, 0, 0, 16'h0000, 0);
        tbl[2]  = mk(0, 0, 0, 125, 0, 0, 0, 16'h0000, 0);
        tbl[3]  = mk(1, 32'h7F00, 0, 125, 1, 0, 32'd62, 16'h0000, 0);
        tbl[4]  = mk(1, 32'h7F04, 0, 125, 1, 0, 32'd125, 16'h0000, 0);
        tbl[5]  = mk(1, 32'h7F0C, 0, 125, 1, 0, 32'h1, 16'h0000, 0);
        tbl[6]  = mk(1, 32'h7F0C, 0, 125, 1, 0, 32'h0, 16'h0000, 0);
        tbl[7]  = mk(2, 32'h7F08, 32'hABCD_1E46, 125, 1, 0, 0, 16'h1E46, 1);
        tbl[8]  = mk(1, 32'h7F0C, 0, 125, 1, 0, 32'h0102, 16'h1E46, 1);
        tbl[9]  = mk(1, 32'h7F00, 0, 125, 1, 0, 32'd62, 16'h1E46, 1);
        tbl[10] = mk(2, 32'h7F08, 32'h0000_1234, 125, 1, 0, 0, 16'h1234, 1);
        tbl[11] = mk(1, 32'h7F08, 0, 125, 1, 0, 32'h1234, 16'h1234, 1);
        tbl[12] = mk(1, 32'h7F0C, 0, 125, 1, 0, 32'h0202, 16'h1234, 1);
        tbl[13] = mk(2, 32'h7F00, 32'hFFFF_FFFF, 125, 1, 1, 0, 16'h1234, 1);
        tbl[14] = mk(1, 32'h7F03, 0, 125, 1, 0, 32'd62, 16'h1234, 1);
        tbl[15] = mk(2, 32'h7F10, 32'h0000_5555, 125, 0, 0, 0, 16'h1234, 1);
        tbl[16] = mk(1, 32'h7F10, 0, 125, 0, 0, 0, 16'h1234, 1);
        tbl[17] = mk(1, 32'h7EFC, 0, 125, 0, 0, 0, 16'h1234, 1);
        tbl[18] = mk(0, 0, 0, 8'h55, 0, 0, 0, 16'h1234, 1);
        tbl[19] = mk(0, 0, 0, 8'h55, 0, 0, 0, 16'h1234, 1);
        tbl[20] = mk(1, 32'h7F0C, 0, 8'h55, 1, 0, 32'h0202, 16'h1234, 1);
        tbl[21] = mk(1, 32'h7F0C, 0, 8'h55, 1, 0, 32'h0203, 16'h1234, 1);
        tbl[22] = mk(1, 32'h7F0C, 0, 8'h55, 1, 0, 32'h0202, 16'h1234, 1);
        tbl[23] = mk(1, 32'h7F04, 0, 8'h55, 1, 0, 32'h55, 16'h1234, 1);
        tbl[24] = mk(2, 32'h7F0C, 32'hFFFF_FFFD, 8'h55, 1, 0, 0, 16'h1234, 1);
        tbl[25] = mk(1, 32'h7F0C, 0, 8'h55, 1, 0, 32'h0202, 16'h1234, 1);
        tbl[26] = mk(2, 32'h7F04, 32'h1, 8'h55, 1, 1, 0, 16'h1234, 1);
        tbl[27] = mk(1, 32'h7F04, 0, 8'h55, 1, 0, 32'h55, 16'h1234, 1);

        repeat (3) @(posedge clk);
        #1;
        chk("reset_ack", 32'(mmio.bus_ack), 32'h0);
        chk("reset_err", 32'(mmio.bus_err), 32'h0);
        chk("reset_rdata", mmio.bus_rdata, 32'h0);
        chk("reset_result", 32'(result), 32'h0);
        chk("reset_valid", 32'(result_valid), 32'h0);
        rst_n = 1'b1;
        model_reset();

        for (int i = 0; i < 28; i++) begin
            opr2_pin = tbl[i].o2;
            step(tbl[i].op != 2'd0, tbl[i].op == 2'd2, tbl[i].addr, tbl[i].wdata);
            chk($sformatf("row%0d_ack", i), 32'(mmio.bus_ack), 32'(tbl[i].eack));
            chk($sformatf("row%0d_err", i), 32'(mmio.bus_err), 32'(tbl[i].eerr));
            if (tbl[i].eack) chk($sformatf("row%0d_rdata", i), mmio.bus_rdata, tbl[i].erd);
            chk($sformatf("row%0d_result", i), 32'(result), 32'(tbl[i].eres));
            chk($sformatf("row%0d_valid", i), 32'(result_valid), 32'(tbl[i].erv));
        end

        for (int i = 0; i < 300; i++) step(1'b1, 1'b1, BASE + 32'h8, $urandom);
        last_res = result;
        step(1'b1, 1'b0, BASE + 32'hC, 0);
        chk("wcnt_saturated", mmio.bus_rdata, 32'h0000_FF02);
        step(1'b1, 1'b1, BASE + 32'hC, 32'h2);
        chk("w1c_valid", 32'(result_valid), 32'h0);
        chk("w1c_result_held", 32'(result), 32'(last_res));
        step(1'b1, 1'b0, BASE + 32'hC, 0);
        chk("w1c_status", mmio.bus_rdata, 32'h0000_FF00);
        step(1'b1, 1'b1, BASE + 32'h8, 32'h0000_0ACE);
        step(1'b1, 1'b1, BASE + 32'hC, 32'h2);
        chk("b2b_clear_wins", 32'(result_valid), 32'h0);
        step(1'b1, 1'b1, BASE + 32'h8, 32'h0000_0BEE);
        chk("b2b_write_wins", 32'(result_valid), 32'h1);

        // Reset lands while the ack for an accepted read is on the bus.
        mmio.bus_req = 1'b1; mmio.bus_we = 1'b0; mmio.bus_addr = BASE;
        @(posedge clk);
        #2 rst_n = 1'b0;
        mmio.bus_req = 1'b0;
        #1;
        chk("midrst_ack", 32'(mmio.bus_ack), 32'h0);
        chk("midrst_err", 32'(mmio.bus_err), 32'h0);
        chk("midrst_rdata", mmio.bus_rdata, 32'h0);
        chk("midrst_result", 32'(result), 32'h0);
        chk("midrst_valid", 32'(result_valid), 32'h0);
        @(posedge clk);
        #1 rst_n = 1'b1;
        model_reset();
        for (int i = 0; i < 3; i++) begin
            step(1'b0, 1'b0, 0, 0);
            chk("postrst_no_ack", 32'(mmio.bus_ack), 32'h0);
        end

        for (int i = 0; i < 600; i++) begin
            if ($urandom_range(0, 7) == 0) opr1_pin = 8'($urandom);
            if ($urandom_range(0, 7) == 0) opr2_pin = 8'($urandom);
            raddr = BASE + 32'($urandom_range(0, 15));
            if ($urandom_range(0, 7) == 0) raddr = BASE + 32'h10 + 32'($urandom_range(0, 255));
            step($urandom_range(0, 3) != 0, $urandom_range(0, 1) == 1, raddr, $urandom);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
